// File: rtl/sign_extend_pkg.sv
// rtl/sign_extend_pkg.sv - shared types, defaults and helpers for the sign/zero extender
package sign_extend_pkg;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

    localparam int unsigned DEF_MAX_INPUT_WIDTH = 8;
    localparam int unsigned DEF_OUTPUT_WIDTH    = 16;
    localparam int unsigned DEF_NUM_LANES       = 2;

    // Bit offset of a lane inside a packed multi-lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    function automatic logic width_legal(input int unsigned w, input int unsigned max);
        return (w != 0) && (w <= max);
    endfunction

endpackage

// File: rtl/sign_extend_lane.sv
// rtl/sign_extend_lane.sv - combinational single-lane sign/zero extender
module sign_extend_lane
    import sign_extend_pkg::*;
#(
    parameter int unsigned MaxInputWidth = DEF_MAX_INPUT_WIDTH,
    parameter int unsigned OutputWidth   = DEF_OUTPUT_WIDTH,
    parameter int unsigned WidthBits     = $clog2(MaxInputWidth + 1)
) (
    input  logic [MaxInputWidth-1:0] i_data,
    input  logic [WidthBits-1:0]     i_width,
    input  logic                     i_mode,
    output logic [OutputWidth-1:0]   o_data
);

    logic                     w_legal;
    logic                     w_fill;
    logic [MaxInputWidth:0]   w_sel_wide;
    logic [MaxInputWidth-1:0] w_sign_sel;
    logic [OutputWidth-1:0]   w_keep;
    logic [OutputWidth-1:0]   w_ext;

    assign w_legal = width_legal(32'(i_width), MaxInputWidth);

    // One-hot pick of bit w-1; the extra top bit keeps w == MaxInputWidth from shifting out.
    assign w_sel_wide = (MaxInputWidth + 1)'(1) << i_width;
    assign w_sign_sel = w_sel_wide[MaxInputWidth:1];
    assign w_fill     = (ext_mode_e'(i_mode) == EXT_SIGN) && (|(i_data & w_sign_sel));

    assign w_keep = ~({OutputWidth{1'b1}} << i_width);
    assign w_ext  = OutputWidth'(i_data);

    assign o_data = w_legal ? ((w_ext & w_keep) | (~w_keep & {OutputWidth{w_fill}})) : '0;

endmodule

// File: rtl/sign_extend_pipe.sv
// rtl/sign_extend_pipe.sv - pipelined multi-lane sign/zero extender with skid-buffered handshake
module sign_extend_pipe
    import sign_extend_pkg::*;
#(
    parameter int unsigned MaxInputWidth = DEF_MAX_INPUT_WIDTH,
    parameter int unsigned OutputWidth   = DEF_OUTPUT_WIDTH,
    parameter int unsigned NumLanes      = DEF_NUM_LANES,
    localparam int unsigned WidthBits    = $clog2(MaxInputWidth + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NumLanes*MaxInputWidth-1:0] in_data,
    input  logic [WidthBits-1:0]              in_width,
    input  logic                              in_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NumLanes*OutputWidth-1:0]   out_data,
    output logic                              out_err
);

    if (OutputWidth < MaxInputWidth) begin : g_bad_cfg
        $error("sign_extend_pipe: OutputWidth must be >= MaxInputWidth");
    end

    logic [NumLanes*OutputWidth-1:0] w_ext_data;
    logic                            w_in_err;
    logic                            w_in_fire;
    logic                            w_out_free;

    logic                            r_out_valid;
    logic [NumLanes*OutputWidth-1:0] r_out_data;
    logic                            r_out_err;
    logic                            r_skid_valid;
    logic [NumLanes*OutputWidth-1:0] r_skid_data;
    logic                            r_skid_err;

    for (genvar k = 0; k < NumLanes; k++) begin : g_lane
        sign_extend_lane #(
            .MaxInputWidth (MaxInputWidth),
            .OutputWidth   (OutputWidth),
            .WidthBits     (WidthBits)
        ) u_lane (
            .i_data  (in_data[lane_lsb(k, MaxInputWidth) +: MaxInputWidth]),
            .i_width (in_width),
            .i_mode  (in_mode),
            .o_data  (w_ext_data[lane_lsb(k, OutputWidth) +: OutputWidth])
        );
    end

    assign w_in_err   = !width_legal(32'(in_width), MaxInputWidth);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_free = !r_out_valid || out_ready;

    // Output stage refills from the skid first so ordering is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_out_err    <= r_skid_err;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out_data <= w_ext_data;
                    r_out_err  <= w_in_err;
                end
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_ext_data;
            r_skid_err   <= w_in_err;
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_sign_extend_pipe.sv
// tb/tb_sign_extend_pipe.sv - scoreboard bench for sign_extend_pipe
module tb_sign_extend_pipe;

    localparam int MW = 8;
    localparam int OW = 16;
    localparam int NL = 2;
    localparam int WB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NL*MW-1:0]  in_data;
    logic [WB-1:0]     in_width;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [NL*OW-1:0]  out_data;
    logic              out_err;

    typedef struct packed {
        logic [NL*OW-1:0] data;
        logic             err;
    } beat_t;

    beat_t sb[$];
    beat_t exp_beat;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_popped = 0;
    bit    tput_check_en = 1'b0;
    bit    prev_out_ready = 1'b0;

    sign_extend_pipe #(
        .MaxInputWidth (MW),
        .OutputWidth   (OW),
        .NumLanes      (NL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_width  (in_width),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] ref_lane(input logic [MW-1:0] d, input int w, input bit mode);
        logic [OW-1:0] r;
        r = '0;
        if (w < 1 || w > MW) return '0;
        for (int i = 0; i < OW; i++) begin
            if (i < w) r[i] = d[i];
            else       r[i] = mode ? d[w-1] : 1'b0;
        end
        return r;
    endfunction

    function automatic beat_t ref_beat(input logic [NL*MW-1:0] d, input int w, input bit mode);
        beat_t b;
        for (int k = 0; k < NL; k++) b.data[k*OW +: OW] = ref_lane(d[k*MW +: MW], w, mode);
        b.err = (w < 1 || w > MW);
        return b;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_beat: got data=%h err=%b, required no beat", out_data, out_err);
                end else begin
                    exp_beat = sb.pop_front();
                    n_popped++;
                    if ({out_data, out_err} !== exp_beat) begin
                        n_fail++;
                        $display("FAIL sb_beat: got data=%h err=%b, required data=%h err=%b",
                                 out_data, out_err, exp_beat.data, exp_beat.err);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(ref_beat(in_data, int'(in_width), in_mode));
            if (tput_check_en && prev_out_ready) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL throughput_in_ready: got %b, required 1 after out_ready=1", in_ready);
                end
            end
            prev_out_ready = out_ready;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NL*MW-1:0] d, input logic [WB-1:0] w, input logic m);
        bit acc = 1'b0;
        int t = 0;
        in_data  = d;
        in_width = w;
        in_mode  = m;
        in_valid = 1'b1;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", t);
        end
    endtask

    task automatic drain();
        int t = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d beats outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_width  = WB'(8);
        in_mode   = 1'b0;
        out_ready = 1'b1;
        #2;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
        if (out_err !== 1'b0)   begin n_fail++; $display("FAIL reset_out_err: got %b, required 0", out_err); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_width();
        out_ready = 1'b1;
        send(16'h7F80, WB'(8), 1'b1);
        in_valid = 1'b0;
        n_checks += 3;
        if (out_valid !== 1'b1)        begin n_fail++; $display("FAIL full_latency: got out_valid=%b, required 1", out_valid); end
        if (out_data !== 32'h007F_FF80) begin n_fail++; $display("FAIL full_data: got %h, required 007fff80", out_data); end
        if (out_err !== 1'b0)          begin n_fail++; $display("FAIL full_err: got %b, required 0", out_err); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_idle: got out_valid=%b, required 0", out_valid); end
    endtask

    task automatic test_width4();
        out_ready = 1'b1;
        send(16'h37A9, WB'(4), 1'b1);
        n_checks++;
        if (out_data !== 32'h0007_FFF9) begin n_fail++; $display("FAIL w4_sign: got %h, required 0007fff9", out_data); end
        send(16'h37A9, WB'(4), 1'b0);
        n_checks++;
        if (out_data !== 32'h0007_0009) begin n_fail++; $display("FAIL w4_zero: got %h, required 00070009", out_data); end
        send(16'h0709, WB'(4), 1'b0);
        n_checks++;
        if (out_data !== 32'h0007_0009) begin n_fail++; $display("FAIL w4_upper_ignored: got %h, required 00070009", out_data); end
        send(16'h0101, WB'(1), 1'b1);
        n_checks++;
        if (out_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL w1_sign: got %h, required ffffffff", out_data); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal_width();
        out_ready = 1'b1;
        send(16'hFFFF, WB'(0), 1'b1);
        n_checks += 2;
        if (out_data !== '0)  begin n_fail++; $display("FAIL w0_data: got %h, required 0", out_data); end
        if (out_err !== 1'b1) begin n_fail++; $display("FAIL w0_err: got %b, required 1", out_err); end
        send(16'h1234, WB'(9), 1'b1);
        n_checks += 2;
        if (out_data !== '0)  begin n_fail++; $display("FAIL w9_data: got %h, required 0", out_data); end
        if (out_err !== 1'b1) begin n_fail++; $display("FAIL w9_err: got %b, required 1", out_err); end
        send(16'h0281, WB'(8), 1'b0);
        n_checks += 2;
        if (out_data !== 32'h0002_0081) begin n_fail++; $display("FAIL legal_after_err_data: got %h, required 00020081", out_data); end
        if (out_err !== 1'b0)          begin n_fail++; $display("FAIL legal_after_err_err: got %b, required 0", out_err); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom), WB'(8 - (i % 8)), i[0]);
            n_checks += 2;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid: beat %0d got %b, required 1", i, out_valid); end
            if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL b2b_in_ready: beat %0d got %b, required 1", i, in_ready); end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [NL*MW-1:0] bp [5];
        logic [NL*OW-1:0] held;
        int idx = 0;
        int cyc = 0;
        int popped0 = n_popped;
        bit saw_low = 1'b0;
        bit stalled_prev = 1'b0;
        bit fire;
        bp[0] = 16'h8001; bp[1] = 16'h7F82; bp[2] = 16'hC033; bp[3] = 16'h0CF4; bp[4] = 16'hA5E5;
        held = '0;
        while (idx < 5 && cyc < 40) begin
            in_valid  = 1'b1;
            in_data   = bp[idx];
            in_width  = WB'(8);
            in_mode   = 1'b1;
            out_ready = !(cyc >= 2 && cyc < 5);
            @(negedge clk);
            if (!in_ready) saw_low = 1'b1;
            if (out_valid && !out_ready) begin
                if (stalled_prev) begin
                    n_checks++;
                    if (out_data !== held) begin n_fail++; $display("FAIL bp_stable: got %h, required %h", out_data, held); end
                end
                held = out_data;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) idx++;
            cyc++;
        end
        drain();
        n_checks += 2;
        if (!saw_low) begin n_fail++; $display("FAIL bp_in_ready_drop: got in_ready never low, required low once skid full"); end
        if (n_popped - popped0 != 5) begin n_fail++; $display("FAIL bp_count: got %0d beats, required 5", n_popped - popped0); end
    endtask

    task automatic test_random();
        int acc = 0;
        int cyc = 0;
        bit fire = 1'b0;
        in_valid = 1'b0;
        tput_check_en = 1'b1;
        while (acc < 2000 && cyc < 20000) begin
            if (!in_valid || fire) begin
                in_valid = ($urandom % 10) < 7;
                in_data  = 16'($urandom);
                in_width = WB'($urandom_range(0, 9));
                in_mode  = 1'($urandom);
            end
            out_ready = ($urandom % 10) < 7;
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) acc++;
            cyc++;
        end
        tput_check_en = 1'b0;
        drain();
        n_checks++;
        if (acc != 2000) begin n_fail++; $display("FAIL rand_beats: got %0d accepted, required 2000", acc); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(16'h1111, WB'(8), 1'b1);
        send(16'h2222, WB'(8), 1'b1);
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_skid_full: got in_ready=%b, required 0", in_ready); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_out_valid: got %b, required 0", out_valid); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL mid_async_in_ready: got %b, required 1", in_ready); end
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_beat: cycle %0d got out_valid=%b, required 0", i, out_valid); end
        end
        tick();
        send(16'h0605, WB'(3), 1'b1);
        n_checks++;
        if (out_data !== 32'hFFFE_FFFD) begin n_fail++; $display("FAIL mid_first_after: got %h, required fffefffd", out_data); end
        drain();
    endtask

    initial begin
        test_reset();
        test_full_width();
        test_width4();
        test_illegal_width();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
